// File: rtl/player_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the player controller slice:
//            the game state encoding and the start position.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Game state machine encoding, explicit 2-bit width.
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    DEAD = 2'd1,
    WIN  = 2'd2
  } game_state_t;

  // The player always starts on the bottom row.
  localparam int START_ROW = 0;

  // Start column is the middle of the playfield (rounded down).
  function automatic int start_col(input int cols);
    return cols / 2;
  endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/player_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : player_ctrl_if
// Purpose  : Bundles the move pulses, hit/restart controls and the player
//            status outputs of player_ctrl.
// Ports    : up_p/down_p/left_p/right_p - one-cycle move pulses
//            hit                         - car on the player's cell (level)
//            restart                     - one-cycle new-game pulse
//            row/col/score               - player position and best row
//            alive/win/moved             - game status and move pulse
// Modports : master - stimulus side (input stage / lane logic)
//            slave  - player_ctrl side
// Revision : 1.0 - initial release
// ============================================================================
interface player_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          up_p;
  logic          down_p;
  logic          left_p;
  logic          right_p;
  logic          hit;
  logic          restart;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [RW-1:0] score;
  logic          alive;
  logic          win;
  logic          moved;

  modport master (
    output up_p, down_p, left_p, right_p, hit, restart,
    input  row, col, score, alive, win, moved
  );

  modport slave (
    input  up_p, down_p, left_p, right_p, hit, restart,
    output row, col, score, alive, win, moved
  );

endinterface : player_ctrl_if
`default_nettype wire

// File: rtl/player_ctrl_move_decode.sv
`default_nettype none
// ============================================================================
// Module   : move_decode
// Purpose  : Combinational move decoder. A move is valid only when exactly
//            one direction pulse is high and the target cell lies on the
//            playfield; otherwise the position is passed through unchanged.
// Ports    : i_up/i_down/i_left/i_right - direction pulses
//            i_row/i_col                 - current position
//            o_move_valid                - an in-bounds single move
//            o_move_up                   - the valid move is an up move
//            o_next_row/o_next_col       - position after the move
// Revision : 1.0 - initial release
// ============================================================================
module move_decode #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  wire logic                    i_up,
  input  wire logic                    i_down,
  input  wire logic                    i_left,
  input  wire logic                    i_right,
  input  wire logic [$clog2(ROWS)-1:0] i_row,
  input  wire logic [$clog2(COLS)-1:0] i_col,
  output logic                         o_move_valid,
  output logic                         o_move_up,
  output logic [$clog2(ROWS)-1:0]      o_next_row,
  output logic [$clog2(COLS)-1:0]      o_next_col
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0] c_TOP_ROW   = RW'(ROWS - 1);
  localparam logic [CW-1:0] c_RIGHT_COL = CW'(COLS - 1);

  logic [2:0] w_pulse_cnt;
  logic       w_one_hot;

  assign w_pulse_cnt = 3'(i_up) + 3'(i_down) + 3'(i_left) + 3'(i_right);
  assign w_one_hot   = (w_pulse_cnt == 3'd1);

  always_comb begin
    o_move_valid = 1'b0;
    o_move_up    = 1'b0;
    o_next_row   = i_row;
    o_next_col   = i_col;
    if (w_one_hot) begin
      // Moves at the edge of the playfield are dropped, not wrapped.
      if (i_up && (i_row != c_TOP_ROW)) begin
        o_move_valid = 1'b1;
        o_move_up    = 1'b1;
        o_next_row   = i_row + RW'(1);
      end else if (i_down && (i_row != '0)) begin
        o_move_valid = 1'b1;
        o_next_row   = i_row - RW'(1);
      end else if (i_left && (i_col != '0)) begin
        o_move_valid = 1'b1;
        o_next_col   = i_col - CW'(1);
      end else if (i_right && (i_col != c_RIGHT_COL)) begin
        o_move_valid = 1'b1;
        o_next_col   = i_col + CW'(1);
      end
    end
  end

endmodule : move_decode
`default_nettype wire

// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_ctrl
// Purpose  : Player position, score and PLAY/DEAD/WIN game state machine
//            for the ROWS x COLS LED playfield. All outputs are registered.
// Ports    : clk   - clock
//            reset - synchronous, active-high reset
//            bus   - player_ctrl_if.slave (move pulses, hit, restart in;
//                    row, col, score, alive, win, moved out)
// Options  : MOVE_COOLDOWN_EN - when defined, an accepted move blocks all
//            further moves for COOLDOWN cycles.
// Revision : 1.0 - initial release
// ============================================================================
module player_ctrl
  import game_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int COOLDOWN = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  player_ctrl_if.slave  bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0] c_START_ROW = RW'(START_ROW);
  localparam logic [CW-1:0] c_START_COL = CW'(start_col(COLS));
  localparam logic [RW-1:0] c_TOP_ROW   = RW'(ROWS - 1);

  // An illegal parameter set keeps the player parked at the start cell
  // instead of producing wrapped positions.
  localparam logic c_CFG_OK = (ROWS >= 2) && (COLS >= 2) && (COOLDOWN >= 1);

  game_state_t   r_state, w_state_n;
  logic [RW-1:0] r_row,   w_row_n;
  logic [CW-1:0] r_col,   w_col_n;
  logic [RW-1:0] r_score, w_score_n;
  logic          r_moved, w_moved_n;
  logic          r_alive, w_alive_n;
  logic          r_win,   w_win_n;

  logic          w_move_en;
  logic          w_move_valid;
  logic          w_move_up;
  logic [RW-1:0] w_dec_row;
  logic [CW-1:0] w_dec_col;

`ifdef MOVE_COOLDOWN_EN
  localparam int CDW = $clog2(COOLDOWN + 1);
  localparam logic [CDW-1:0] c_COOLDOWN = CDW'(COOLDOWN);

  logic [CDW-1:0] r_cd, w_cd_n;

  assign w_move_en = c_CFG_OK && (r_cd == '0);
`else
  assign w_move_en = c_CFG_OK;
`endif

  // Pulses are masked before decoding so a blocked pulse looks like no move.
  move_decode #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_move_decode (
    .i_up         (bus.up_p    & w_move_en),
    .i_down       (bus.down_p  & w_move_en),
    .i_left       (bus.left_p  & w_move_en),
    .i_right      (bus.right_p & w_move_en),
    .i_row        (r_row),
    .i_col        (r_col),
    .o_move_valid (w_move_valid),
    .o_move_up    (w_move_up),
    .o_next_row   (w_dec_row),
    .o_next_col   (w_dec_col)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PLAY;
      r_row   <= c_START_ROW;
      r_col   <= c_START_COL;
      r_score <= '0;
      r_moved <= 1'b0;
      r_alive <= 1'b1;
      r_win   <= 1'b0;
`ifdef MOVE_COOLDOWN_EN
      r_cd    <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_score <= w_score_n;
      r_moved <= w_moved_n;
      r_alive <= w_alive_n;
      r_win   <= w_win_n;
`ifdef MOVE_COOLDOWN_EN
      r_cd    <= w_cd_n;
`endif
    end
  end

  // Next-state, position, score and cooldown logic.
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_score_n = r_score;
    w_moved_n = 1'b0;
`ifdef MOVE_COOLDOWN_EN
    w_cd_n    = (r_cd != '0) ? (r_cd - CDW'(1)) : '0;
`endif

    if (bus.restart) begin
      w_state_n = PLAY;
      w_row_n   = c_START_ROW;
      w_col_n   = c_START_COL;
      w_score_n = '0;
`ifdef MOVE_COOLDOWN_EN
      w_cd_n    = '0;
`endif
    end else begin
      unique case (r_state)
        PLAY: begin
          if (bus.hit) begin
            // Collision wins over any simultaneous move.
            w_state_n = DEAD;
`ifdef MOVE_COOLDOWN_EN
            w_cd_n    = '0;
`endif
          end else if (w_move_valid) begin
            w_row_n   = w_dec_row;
            w_col_n   = w_dec_col;
            w_moved_n = 1'b1;
`ifdef MOVE_COOLDOWN_EN
            w_cd_n    = c_COOLDOWN;
`endif
            if (w_move_up && (w_dec_row > r_score)) begin
              w_score_n = w_dec_row;
            end
            if (w_move_up && (w_dec_row == c_TOP_ROW)) begin
              w_state_n = WIN;
`ifdef MOVE_COOLDOWN_EN
              w_cd_n    = '0;
`endif
            end
          end
        end
        DEAD, WIN: begin
          // Frozen until restart or reset.
        end
        default: begin
          w_state_n = PLAY;
        end
      endcase
    end

    w_alive_n = (w_state_n != DEAD);
    w_win_n   = (w_state_n == WIN);
  end

  assign bus.row   = r_row;
  assign bus.col   = r_col;
  assign bus.score = r_score;
  assign bus.alive = r_alive;
  assign bus.win   = r_win;
  assign bus.moved = r_moved;

endmodule : player_ctrl
`default_nettype wire

// File: tb/tb_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_ctrl
// Purpose  : Self-checking bench for player_ctrl (ROWS=8, COLS=8,
//            COOLDOWN=4). A behavioural game model is compared with the DUT
//            every cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_ctrl;
  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int COOLDOWN = 4;
`ifdef MOVE_COOLDOWN_EN
  localparam int GAP = 6;
`else
  localparam int GAP = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  player_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  player_ctrl #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  // state: 0 = playing, 1 = dead, 2 = won
  int m_row, m_col, m_score, m_state, m_moved, m_cd;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    int n, nr, nc;
    if (reset || bus.restart) begin
      m_row = 0; m_col = COLS / 2; m_score = 0; m_state = 0;
      m_moved = 0; m_cd = 0;
      if (reset) m_ok = 1'b1;
    end else begin
      m_moved = 0;
      n = int'(bus.up_p) + int'(bus.down_p) + int'(bus.left_p) + int'(bus.right_p);
      nr = m_row + (bus.up_p ? 1 : 0) - (bus.down_p ? 1 : 0);
      nc = m_col + (bus.right_p ? 1 : 0) - (bus.left_p ? 1 : 0);
      if (m_state == 0) begin
        if (bus.hit) begin
          m_state = 1;
          m_cd = 0;
        end else if (n == 1 && m_cd == 0 && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
          m_row = nr; m_col = nc; m_moved = 1;
          if (m_row > m_score) m_score = m_row;
`ifdef MOVE_COOLDOWN_EN
          m_cd = COOLDOWN + 1;  // decremented below in this same step
`endif
          if (m_row == ROWS - 1) begin
            m_state = 2;
            m_cd = 0;
          end
        end
      end
      if (m_cd > 0) m_cd = m_cd - 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok && !reset) begin
      n_tests++;
      if (bus.row !== 3'(m_row) || bus.col !== 3'(m_col) || bus.score !== 3'(m_score) ||
          bus.alive !== (m_state != 1) || bus.win !== (m_state == 2) ||
          bus.moved !== 1'(m_moved)) begin
        n_fail++;
        $display("FAIL model t=%0t: got row=%0d col=%0d score=%0d alive=%0b win=%0b moved=%0b, want row=%0d col=%0d score=%0d alive=%0b win=%0b moved=%0d",
                 $time, bus.row, bus.col, bus.score, bus.alive, bus.win, bus.moved,
                 m_row, m_col, m_score, (m_state != 1), (m_state == 2), m_moved);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit l, input bit r, input bit h);
    bus.up_p = u; bus.down_p = d; bus.left_p = l; bus.right_p = r; bus.hit = h;
    @(negedge clk);
    bus.up_p = 1'b0; bus.down_p = 1'b0; bus.left_p = 1'b0; bus.right_p = 1'b0; bus.hit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.up_p = 1'b0; bus.down_p = 1'b0; bus.left_p = 1'b0; bus.right_p = 1'b0;
    bus.hit = 1'b0; bus.restart = 1'b0;
    @(negedge clk);
    bus.right_p = 1'b1;            // must be ignored during reset
    @(negedge clk);
    bus.right_p = 1'b0;
    reset = 1'b0;
    check("reset_row",   int'(bus.row), 0);
    check("reset_col",   int'(bus.col), 4);
    check("reset_score", int'(bus.score), 0);
    check("reset_alive", int'(bus.alive), 1);
    check("reset_win",   int'(bus.win), 0);
    check("reset_moved", int'(bus.moved), 0);
    idle(2);

    // Right x3, left x1
    pulse(0,0,0,1,0); check("r1_col", int'(bus.col), 5); check("r1_moved", int'(bus.moved), 1); idle(GAP-1);
    check("r1_moved_drop", int'(bus.moved), 0);
    pulse(0,0,0,1,0); check("r2_col", int'(bus.col), 6); check("r2_moved", int'(bus.moved), 1); idle(GAP-1);
    pulse(0,0,0,1,0); check("r3_col", int'(bus.col), 7); check("r3_moved", int'(bus.moved), 1); idle(GAP-1);
    pulse(0,0,1,0,0); check("l1_col", int'(bus.col), 6); check("l1_moved", int'(bus.moved), 1); idle(GAP-1);

    // Clamping and ambiguous moves
    pulse(0,0,0,1,0); check("to7_col", int'(bus.col), 7); idle(GAP-1);
    pulse(0,0,0,1,0); check("clampR_col", int'(bus.col), 7); check("clampR_moved", int'(bus.moved), 0); idle(GAP-1);
    pulse(0,1,0,0,0); check("clampD_row", int'(bus.row), 0); check("clampD_moved", int'(bus.moved), 0); idle(GAP-1);
    pulse(1,0,1,0,0); check("multi_row", int'(bus.row), 0); check("multi_col", int'(bus.col), 7);
    check("multi_moved", int'(bus.moved), 0); idle(GAP-1);

    // Score tracking
    pulse(1,0,0,0,0); check("u1_score", int'(bus.score), 1); idle(GAP-1);
    pulse(1,0,0,0,0); check("u2_score", int'(bus.score), 2); idle(GAP-1);
    pulse(1,0,0,0,0); check("u3_score", int'(bus.score), 3); check("u3_row", int'(bus.row), 3); idle(GAP-1);
    pulse(0,1,0,0,0); check("d1_score", int'(bus.score), 3); idle(GAP-1);
    pulse(0,1,0,0,0); check("d2_score", int'(bus.score), 3); check("d2_row", int'(bus.row), 1); idle(GAP-1);
    pulse(1,0,0,0,0); check("u4_score", int'(bus.score), 3); check("u4_row", int'(bus.row), 2); idle(GAP-1);

    // Hit beats move, DEAD freezes, restart recovers
    pulse(1,0,0,0,1); check("hit_alive", int'(bus.alive), 0); check("hit_row", int'(bus.row), 2);
    check("hit_moved", int'(bus.moved), 0); idle(GAP-1);
    pulse(1,0,0,0,0); check("dead_row", int'(bus.row), 2); check("dead_moved", int'(bus.moved), 0); idle(GAP-1);
    do_restart();
    check("rs1_row", int'(bus.row), 0); check("rs1_col", int'(bus.col), 4);
    check("rs1_score", int'(bus.score), 0); check("rs1_alive", int'(bus.alive), 1);
    idle(GAP-1);

    // Climb to the goal row
    for (int i = 0; i < 7; i++) begin
      pulse(1,0,0,0,0);
      idle(GAP-1);
    end
    check("win_row", int'(bus.row), 7); check("win_score", int'(bus.score), 7);
    check("win_win", int'(bus.win), 1); check("win_alive", int'(bus.alive), 1);
    pulse(1,0,0,0,0); idle(GAP-1);
    pulse(0,0,1,0,0); check("frz_row", int'(bus.row), 7); check("frz_col", int'(bus.col), 4);
    check("frz_moved", int'(bus.moved), 0); idle(GAP-1);
    do_restart();
    check("rs2_win", int'(bus.win), 0); check("rs2_row", int'(bus.row), 0);
    idle(GAP);

    // Up held on six consecutive cycles
    bus.up_p = 1'b1;
    idle(6);
    bus.up_p = 1'b0;
    idle(GAP);
`ifdef MOVE_COOLDOWN_EN
    check("burst_row", int'(bus.row), 2);
`else
    check("burst_row", int'(bus.row), 6);
`endif
    check("burst_alive", int'(bus.alive), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule : tb_player_ctrl
`default_nettype wire
